// File: rtl/spi_mem_responder_pkg.sv
// rtl/spi_mem_responder_pkg.sv - shared SPI memory responder opcodes, field sizes and state encoding
package spi_mem_responder_pkg;

   localparam logic [7:0] SPI_CMD_READ  = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
   localparam int         CMD_BITS      = 8;
   localparam int         ADDR_BITS     = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } spi_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - two-flop synchronisers and edge detection for SPI target inputs
module spi_in_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic cs_n_in,
   input  logic sclk_in,
   input  logic mosi_in,
   output logic cs_n,
   output logic cs_fall,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic mosi
);

   logic [1:0] cs_q;
   logic [1:0] sclk_q;
   logic [1:0] mosi_q;
   logic       sclk_d;

   // Resynchronise the asynchronous pins; cs_n idles high so a reset never looks like a select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_q   <= 2'b11;
         sclk_q <= 2'b00;
         mosi_q <= 2'b00;
         sclk_d <= 1'b0;
      end else begin
         cs_q   <= {cs_q[0], cs_n_in};
         sclk_q <= {sclk_q[0], sclk_in};
         mosi_q <= {mosi_q[0], mosi_in};
         sclk_d <= sclk_q[1];
      end
   end

   assign cs_n      = cs_q[1];
   // Flagged one clk early so the select starts while cs_n still reads high to the load port.
   assign cs_fall   = cs_q[1] & ~cs_q[0];
   assign sclk_rise = sclk_q[1] & ~sclk_d;
   assign sclk_fall = ~sclk_q[1] & sclk_d;
   assign mosi      = mosi_q[1];

endmodule

// File: rtl/spi_mem_responder.sv
// rtl/spi_mem_responder.sv - SPI mode-0 read/write memory target with host backdoor load port
module spi_mem_responder
   import spi_mem_responder_pkg::*;
#(
   parameter int         MEM_BYTES = 8192,
   parameter int         ADDR_W    = 13,
   parameter int         WRITABLE  = 1,
   parameter logic [7:0] READ_CMD  = SPI_CMD_READ,
   parameter logic [7:0] WRITE_CMD = SPI_CMD_WRITE
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_cs_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [7:0]        load_data,
   output logic              load_ready,
   output logic              busy
);

   logic              cs_n_s;
   logic              cs_fall;
   logic              sclk_rise;
   logic              sclk_fall;
   logic              mosi_s;

   spi_state_t        state;
   logic [4:0]        bit_cnt;
   logic [6:0]        shift_in;
   logic [7:0]        rx_byte;
   logic [ADDR_W-1:0] addr;
   logic              is_write;
   logic [7:0]        tx_shift;
   logic              fetch;
   logic              wr_pend;
   logic [7:0]        wr_byte;
   logic [7:0]        mem [MEM_BYTES];

   spi_in_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs_n_in   (spi_cs_n),
      .sclk_in   (spi_sclk),
      .mosi_in   (spi_mosi),
      .cs_n      (cs_n_s),
      .cs_fall   (cs_fall),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .mosi      (mosi_s)
   );

   assign rx_byte    = {shift_in, mosi_s};
   assign load_ready = cs_n_s && (state == ST_IDLE);
   assign busy       = ~cs_n_s;

   // Transaction FSM: command decode, address capture, read prefetch/shift-out and write staging.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         bit_cnt     <= '0;
         shift_in    <= '0;
         addr        <= '0;
         is_write    <= 1'b0;
         tx_shift    <= '0;
         fetch       <= 1'b0;
         wr_pend     <= 1'b0;
         wr_byte     <= '0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
      end else begin
         fetch   <= 1'b0;
         wr_pend <= 1'b0;
         if (fetch) begin
            tx_shift <= mem[addr];
            addr     <= addr + 1'b1;
         end
         if (wr_pend) begin
            addr <= addr + 1'b1;
         end
         if (state != ST_IDLE && cs_n_s) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  spi_miso    <= 1'b0;
                  spi_miso_oe <= 1'b0;
                  bit_cnt     <= '0;
                  if (cs_fall) begin
                     state <= ST_CMD;
                  end
               end
               ST_CMD: begin
                  if (sclk_rise) begin
                     shift_in <= rx_byte[6:0];
                     bit_cnt  <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'(CMD_BITS - 1)) begin
                        bit_cnt <= '0;
                        if (rx_byte == READ_CMD) begin
                           state    <= ST_ADDR;
                           is_write <= 1'b0;
                        end else if (WRITABLE != 0 && rx_byte == WRITE_CMD) begin
                           state    <= ST_ADDR;
                           is_write <= 1'b1;
                        end else begin
                           state <= ST_IGNORE;
                        end
                     end
                  end
               end
               ST_ADDR: begin
                  if (sclk_rise) begin
                     addr    <= {addr[ADDR_W-2:0], mosi_s};
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                        bit_cnt <= '0;
                        if (is_write) begin
                           state <= ST_WDATA;
                        end else begin
                           state <= ST_RDATA;
                           fetch <= 1'b1;
                        end
                     end
                  end
               end
               ST_RDATA: begin
                  if (sclk_fall) begin
                     spi_miso    <= tx_shift[7];
                     spi_miso_oe <= 1'b1;
                     tx_shift    <= {tx_shift[6:0], 1'b0};
                  end
                  if (sclk_rise) begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        fetch   <= 1'b1;
                     end
                  end
               end
               ST_WDATA: begin
                  if (sclk_rise) begin
                     shift_in <= rx_byte[6:0];
                     bit_cnt  <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt <= '0;
                        wr_byte <= rx_byte;
                        wr_pend <= 1'b1;
                     end
                  end
               end
               ST_IGNORE: begin
                  spi_miso    <= 1'b0;
                  spi_miso_oe <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Byte array write port; SPI writes occur only outside IDLE and loads only in IDLE, so they never collide.
   always_ff @(posedge clk) begin
      if (wr_pend) begin
         mem[addr] <= wr_byte;
      end else if (load_en && load_ready) begin
         mem[load_addr] <= load_data;
      end
   end

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb/tb_spi_mem_responder.sv - directed bench for spi_mem_responder (writable and flash-like instances)
module tb_spi_mem_responder;

   localparam int HALF = 6;

   logic        clk;
   logic        rst_n;
   logic        sclk;
   logic        mosi;
   logic        cs_a, cs_b;
   logic        miso_a, miso_b;
   logic        oe_a, oe_b;
   logic        busy_a, busy_b;
   logic        lr_a, lr_b;
   logic        ld_en_a, ld_en_b;
   logic [12:0] ld_addr_a, ld_addr_b;
   logic [7:0]  ld_data_a, ld_data_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd;
   logic [31:0] rd_oe;
   logic [7:0]  h_rx, h_oe, b_rx, b_oe;

   spi_mem_responder #(.WRITABLE(1)) dut (
      .clk (clk), .rst_n (rst_n),
      .spi_cs_n (cs_a), .spi_sclk (sclk), .spi_mosi (mosi),
      .spi_miso (miso_a), .spi_miso_oe (oe_a),
      .load_en (ld_en_a), .load_addr (ld_addr_a), .load_data (ld_data_a),
      .load_ready (lr_a), .busy (busy_a)
   );

   spi_mem_responder #(.WRITABLE(0)) dut_ro (
      .clk (clk), .rst_n (rst_n),
      .spi_cs_n (cs_b), .spi_sclk (sclk), .spi_mosi (mosi),
      .spi_miso (miso_b), .spi_miso_oe (oe_b),
      .load_en (ld_en_b), .load_addr (ld_addr_b), .load_data (ld_data_b),
      .load_ready (lr_b), .busy (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load_mem(input logic sel, input logic [12:0] a, input logic [7:0] d);
      @(negedge clk);
      if (sel) begin ld_en_b = 1'b1; ld_addr_b = a; ld_data_b = d; end
      else     begin ld_en_a = 1'b1; ld_addr_a = a; ld_data_a = d; end
      @(negedge clk);
      ld_en_a = 1'b0;
      ld_en_b = 1'b0;
   endtask

   task automatic spi_start(input logic sel);
      @(negedge clk);
      if (sel) cs_b = 1'b0; else cs_a = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic spi_stop(input logic sel);
      repeat (HALF) @(negedge clk);
      if (sel) cs_b = 1'b1; else cs_a = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic spi_bits(input logic sel, input logic [7:0] tx, input int n,
                           output logic [7:0] rx, output logic [7:0] oe);
      rx = '0;
      oe = '0;
      for (int i = 0; i < n; i++) begin
         mosi = tx[7-i];
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         rx = {rx[6:0], (sel ? miso_b : miso_a)};
         oe = {oe[6:0], (sel ? oe_b : oe_a)};
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic spi_hdr(input logic sel, input logic [7:0] cmd, input logic [23:0] a,
                          output logic [7:0] rx_or, output logic [7:0] oe_or);
      logic [7:0] r, o;
      logic [31:0] w;
      w = {cmd, a};
      rx_or = '0;
      oe_or = '0;
      for (int k = 0; k < 4; k++) begin
         spi_bits(sel, w[31-8*k -: 8], 8, r, o);
         rx_or = rx_or | r;
         oe_or = oe_or | o;
      end
   endtask

   task automatic spi_read(input logic sel, input logic [23:0] a, input int n,
                           output logic [31:0] data, output logic [31:0] oe_d, output logic [7:0] hoe);
      logic [7:0] r, o, hr;
      data = '0;
      oe_d = '0;
      spi_start(sel);
      spi_hdr(sel, 8'h03, a, hr, hoe);
      for (int k = 0; k < n; k++) begin
         spi_bits(sel, 8'h00, 8, r, o);
         data = {data[23:0], r};
         oe_d = {oe_d[23:0], o};
      end
      spi_stop(sel);
   endtask

   initial begin
      rst_n = 1'b0;
      sclk = 1'b0; mosi = 1'b0; cs_a = 1'b1; cs_b = 1'b1;
      ld_en_a = 1'b0; ld_addr_a = '0; ld_data_a = '0;
      ld_en_b = 1'b0; ld_addr_b = '0; ld_data_b = '0;
      repeat (3) @(negedge clk);
      check("rst_miso", {31'd0, miso_a}, 32'd0);
      check("rst_oe", {31'd0, oe_a}, 32'd0);
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      check("rst_load_ready", {31'd0, lr_a}, 32'd1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // preload and stream 4 bytes back
      load_mem(0, 13'h100, 8'hDE);
      load_mem(0, 13'h101, 8'hAD);
      load_mem(0, 13'h102, 8'hBE);
      load_mem(0, 13'h103, 8'hEF);
      spi_read(0, 24'h000100, 4, rd, rd_oe, h_oe);
      check("rd_data", rd, 32'hDEADBEEF);
      check("rd_hdr_oe", {24'd0, h_oe}, 32'd0);
      check("rd_data_oe", rd_oe, 32'hFFFFFFFF);
      check("rd_end_oe", {31'd0, oe_a}, 32'd0);
      check("rd_end_busy", {31'd0, busy_a}, 32'd0);

      // two-byte write then read back
      spi_start(0);
      check("wr_busy", {31'd0, busy_a}, 32'd1);
      spi_hdr(0, 8'h02, 24'h000200, h_rx, h_oe);
      spi_bits(0, 8'h11, 8, b_rx, b_oe);
      spi_bits(0, 8'h22, 8, b_rx, b_oe);
      check("wr_oe", {24'd0, (h_oe | b_oe)}, 32'd0);
      spi_stop(0);
      spi_read(0, 24'h000200, 2, rd, rd_oe, h_oe);
      check("wr_readback", rd, 32'h00001122);

      // address wrap at the top of the array
      load_mem(0, 13'h1FFF, 8'hA5);
      load_mem(0, 13'h0000, 8'h5A);
      spi_read(0, 24'h001FFF, 2, rd, rd_oe, h_oe);
      check("wrap_data", rd, 32'h0000A55A);

      // flash-like instance ignores write
      load_mem(1, 13'h010, 8'h33);
      spi_start(1);
      spi_hdr(1, 8'h02, 24'h000010, h_rx, h_oe);
      spi_bits(1, 8'h77, 8, b_rx, b_oe);
      check("ro_miso", {24'd0, (h_rx | b_rx)}, 32'd0);
      check("ro_oe", {24'd0, (h_oe | b_oe)}, 32'd0);
      spi_stop(1);
      spi_read(1, 24'h000010, 1, rd, rd_oe, h_oe);
      check("ro_unchanged", rd, 32'h00000033);

      // partial byte on deselect is discarded
      load_mem(0, 13'h300, 8'h44);
      spi_start(0);
      spi_hdr(0, 8'h02, 24'h000300, h_rx, h_oe);
      spi_bits(0, 8'hFF, 5, b_rx, b_oe);
      @(negedge clk);
      cs_a = 1'b1;
      repeat (3) @(negedge clk);
      check("partial_busy", {31'd0, busy_a}, 32'd0);
      repeat (4) @(negedge clk);
      spi_read(0, 24'h000300, 1, rd, rd_oe, h_oe);
      check("partial_unchanged", rd, 32'h00000044);

      // reset in the middle of a read address phase
      spi_start(0);
      spi_bits(0, 8'h03, 8, b_rx, b_oe);
      spi_bits(0, 8'h00, 8, b_rx, b_oe);
      spi_bits(0, 8'h01, 8, b_rx, b_oe);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_miso", {31'd0, miso_a}, 32'd0);
      check("mid_rst_oe", {31'd0, oe_a}, 32'd0);
      check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
      cs_a = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      spi_read(0, 24'h000100, 1, rd, rd_oe, h_oe);
      check("post_rst_read", rd, 32'h000000DE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
